ascon_perm_core: RTL

- Iterative, parametrised Ascon-p[rnd] permutation engine per NIST SP 800-232, operating on the shared 320-bit `ascon_state_t`.
- Applies a run-time selectable number of rounds (1..12) at UNROLL rounds per clock.
- Uses valid/ready handshakes on both sides.
- Shared permutation back-end for the AEAD, hash and XOF controllers: one state in flight, out_state held until consumed.

---
 rtl/ascon_pkg.sv | 67 ++++++
 rtl/ascon_round_chain.sv | 30 +++
 rtl/ascon_perm_core.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: the 320-bit state type, round-count type,
// permutation FSM states, round constant and a single combinational
// Ascon-p round. Word 0 of ascon_state_t is S0.
package ascon_pkg;

    localparam int unsigned NR_MAX = 12;

    typedef logic [4:0][63:0] ascon_state_t;
    typedef logic [3:0]       rnd_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } perm_fsm_t;

    // Round constant for round index idx (0..11): F0, E1, D2, ... 4B.
    function automatic logic [7:0] rc(rnd_t idx);
        return 8'hF0 - ({4'h0, idx} * 8'h0F);
    endfunction

    function automatic logic [63:0] ror64(logic [63:0] x, int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One Ascon round: constant addition, bitsliced S-box, linear layer.
    function automatic ascon_state_t ascon_round(ascon_state_t s, rnd_t idx);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        ascon_state_t r;

        x0 = s[0];
        x1 = s[1];
        x2 = s[2] ^ {56'h0, rc(idx)};
        x3 = s[3];
        x4 = s[4];

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;

        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;

        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;

        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        r[0] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        r[1] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        r[2] = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        r[3] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        r[4] = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return r;
    endfunction

endpackage

// File: rtl/ascon_round_chain.sv
// Combinational chain of UNROLL Ascon rounds with consecutive constant
// indices idx_i .. idx_i+UNROLL-1. Stage j is applied only when j < k_i;
// later stages pass the state through untouched.
//   state_i : state entering the chain
//   idx_i   : constant index of the first stage
//   k_i     : number of stages to apply (0..UNROLL)
//   state_o : state after k_i rounds
module ascon_round_chain
    import ascon_pkg::*;
#(
    parameter int unsigned UNROLL = 1
) (
    input  ascon_state_t state_i,
    input  rnd_t         idx_i,
    input  rnd_t         k_i,
    output ascon_state_t state_o
);

    always_comb begin : p_chain
        ascon_state_t acc;
        acc = state_i;
        for (int unsigned j = 0; j < UNROLL; j++) begin
            if (j < 32'(k_i)) begin
                acc = ascon_round(acc, idx_i + rnd_t'(j));
            end
        end
        state_o = acc;
    end

endmodule

// File: rtl/ascon_perm_core.sv
// Iterative Ascon-p[R] permutation engine, UNROLL rounds per clock.
// One request in flight; the result is held in DONE until consumed.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : request handshake
//   in_state, in_rounds  : state to permute and round count R (legal 1..12)
//   out_valid/out_ready  : result handshake
//   out_state, out_err   : permuted state; out_err=1 flags an illegal R
//   busy                 : high while a request is in RUN or DONE
module ascon_perm_core
    import ascon_pkg::*;
#(
    parameter int unsigned UNROLL = 1,
    parameter int unsigned NR_MAX = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  ascon_state_t in_state,
    input  rnd_t         in_rounds,
    output logic         out_valid,
    input  logic         out_ready,
    output ascon_state_t out_state,
    output logic         out_err,
    output logic         busy
);

    if (UNROLL == 0 || UNROLL > 4) begin : g_bad_unroll
        $error("ascon_perm_core: UNROLL must be in 1..4");
    end
    if (NR_MAX != 12) begin : g_bad_nr_max
        $error("ascon_perm_core: NR_MAX must be 12");
    end

    perm_fsm_t    fsm_q, fsm_d;
    ascon_state_t st_q, st_d;
    rnd_t         rem_q, rem_d;
    rnd_t         idx_q, idx_d;
    logic         err_q, err_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready_q, in_ready_d;
    logic         busy_q, busy_d;

    rnd_t         k;
    logic         in_legal;
    ascon_state_t chain_state;

    assign k        = (rem_q < rnd_t'(UNROLL)) ? rem_q : rnd_t'(UNROLL);
    assign in_legal = (in_rounds != '0) && (in_rounds <= rnd_t'(NR_MAX));

    ascon_round_chain #(
        .UNROLL (UNROLL)
    ) u_chain (
        .state_i (st_q),
        .idx_i   (idx_q),
        .k_i     (k),
        .state_o (chain_state)
    );

    always_comb begin
        fsm_d       = fsm_q;
        st_d        = st_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        case (fsm_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    st_d       = in_state;
                    fsm_d      = RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    if (in_legal) begin
                        rem_d = in_rounds;
                        idx_d = rnd_t'(NR_MAX) - in_rounds;
                        err_d = 1'b0;
                    end else begin
                        // Illegal R spends one empty RUN cycle (k=0) so the
                        // state is returned unchanged with a 1-cycle latency.
                        rem_d = '0;
                        idx_d = rnd_t'(NR_MAX);
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                st_d  = chain_state;
                rem_d = rem_q - k;
                idx_d = idx_q + k;
                if (rem_q == k) begin
                    fsm_d       = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                // in_ready stays low here; the earliest accept is the cycle
                // after the result handshake.
                if (out_ready) begin
                    fsm_d       = IDLE;
                    out_valid_d = 1'b0;
                    err_d       = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            st_q        <= '0;
            rem_q       <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            st_q        <= st_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = st_q;
    assign out_err   = err_q;
    assign busy      = busy_q;

endmodule
